edge_feeder: RTL

Edge-list producer feeding the edge scheduler. On a start pulse it streams `num_edges` 24-bit edge words from the edge memory into an internal first-word-fall-through FIFO. The FIFO's `empty` and `edg` outputs form the scheduler's Task/edge interface: the scheduler's Task input is driven by `~empty`. The scheduler drains the FIFO with `pop`; `done` pulses once the whole list has been fetched and consumed.

---
 rtl/gnn_pkg.sv | 22 ++
 rtl/edge_feeder_if.sv | 26 ++
 rtl/edge_fifo.sv | 52 +++++
 rtl/edge_feeder.sv | 111 +++++++++++
 4 files changed

// File: rtl/gnn_pkg.sv
// Shared GNN datapath types: edge word layout and feeder state encoding.
package gnn_pkg;

  localparam int EDGE_W = 24;
  localparam int NODE_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_DRAIN = 2'b10
  } feed_state_e;

  // Edge word is {src, dst}; the scheduler slices it the same way.
  function automatic logic [NODE_W-1:0] edge_src(input logic [EDGE_W-1:0] e);
    return e[EDGE_W-1:NODE_W];
  endfunction

  function automatic logic [NODE_W-1:0] edge_dst(input logic [EDGE_W-1:0] e);
    return e[NODE_W-1:0];
  endfunction

endpackage

// File: rtl/edge_feeder_if.sv
// Edge-memory read port plus the scheduler-facing FIFO head (Task = ~empty).
interface edge_feeder_if #(
  parameter int EADDR_W = 5,
  parameter int DEPTH   = 16
);
  import gnn_pkg::*;

  logic                    mem_rd_en;
  logic [EADDR_W-1:0]      mem_addr;
  logic [EDGE_W-1:0]       mem_rdata;
  logic [EDGE_W-1:0]       edg;
  logic                    empty;
  logic                    pop;
  logic [$clog2(DEPTH):0]  level;

  modport master (
    output mem_rd_en, mem_addr, edg, empty, level,
    input  mem_rdata, pop
  );

  modport slave (
    input  mem_rd_en, mem_addr, edg, empty, level,
    output mem_rdata, pop
  );

endinterface

// File: rtl/edge_fifo.sv
// First-word-fall-through FIFO of edge words; head is always visible on o_dout.
module edge_fifo
  import gnn_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [EDGE_W-1:0]        i_din,
  input  logic                     i_rd_en,
  output logic [EDGE_W-1:0]        o_dout,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [EDGE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              w_rd;

  // Popping an empty FIFO is a no-op so the head and pointers stay put.
  assign w_rd = i_rd_en && (r_level != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_wr_en) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_wr_en, w_rd})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/edge_feeder.sv
// Streams a contiguous edge list from edge memory into the scheduler FIFO.
// state | meaning
// IDLE  | waiting for start; zero-length start just pulses done
// FETCH | issuing reads while FIFO space (level + inflight) allows
// DRAIN | all reads issued; wait for last return and FIFO empty
module edge_feeder
  import gnn_pkg::*;
#(
  parameter int EADDR_W = 5,
  parameter int DEPTH   = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [EADDR_W-1:0]  i_base_addr,
  input  logic [EADDR_W:0]    i_num_edges,
  output logic                o_busy,
  output logic                o_done,
  edge_feeder_if.master       bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = EADDR_W + 1;

  feed_state_e         r_state;
  feed_state_e         w_state_nxt;
  logic [EADDR_W-1:0]  r_base;
  logic [CNT_W-1:0]    r_num;
  logic [CNT_W-1:0]    r_issued;
  logic [CNT_W-1:0]    w_issued_nxt;
  logic                r_inflight;
  logic                r_done;
  logic                w_done_nxt;
  logic                w_room;
  logic                w_rd_en;
  logic                w_fifo_empty;
  logic [LVL_W-1:0]    w_fifo_level;
  logic [EDGE_W-1:0]   w_fifo_dout;

  // Reserve a slot for the read still in flight so a return never overflows.
  assign w_room       = (w_fifo_level + LVL_W'(r_inflight)) < LVL_W'(DEPTH);
  assign w_rd_en      = (r_state == ST_FETCH) && (r_issued < r_num) && w_room;
  assign w_issued_nxt = r_issued + CNT_W'(w_rd_en);

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_num_edges == '0) w_done_nxt  = 1'b1;
          else                   w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (w_issued_nxt == r_num) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!r_inflight && w_fifo_empty) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_num      <= '0;
      r_issued   <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_done     <= w_done_nxt;
      r_inflight <= w_rd_en;
      if ((r_state == ST_IDLE) && i_start) begin
        r_base   <= i_base_addr;
        r_num    <= i_num_edges;
        r_issued <= '0;
      end else begin
        r_issued <= w_issued_nxt;
      end
    end
  end

  edge_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr_en (r_inflight),
    .i_din   (bus.mem_rdata),
    .i_rd_en (bus.pop),
    .o_dout  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  assign bus.mem_rd_en = w_rd_en;
  assign bus.mem_addr  = r_base + r_issued[EADDR_W-1:0];
  assign bus.edg       = w_fifo_dout;
  assign bus.empty     = w_fifo_empty;
  assign bus.level     = w_fifo_level;
  assign o_busy        = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign o_done        = r_done;

endmodule
